// File: rtl/data_ram_arbiter.sv
// Two-master, single-slave data RAM arbiter for openmips_min_sopc.
// m0 is the CPU data port, m1 the DMA/debug loader. Each beat is one issue
// cycle followed by one ack cycle. m1 is forced in after MAX_WAIT back-to-back
// m0 grants, and may hold the RAM across beats with m1_lock.
// Optional build macro: ARB_PERF_CNT_EN adds perf_m0_stall / perf_conflict.
module data_ram_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW/8-1:0] m0_sel,
  input  logic [DW-1:0]   m0_wdata,
  output logic [DW-1:0]   m0_rdata,
  output logic            m0_ack,
  output logic            m0_stallreq,
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW/8-1:0] m1_sel,
  input  logic [DW-1:0]   m1_wdata,
  input  logic            m1_lock,
  output logic [DW-1:0]   m1_rdata,
  output logic            m1_ack,
  output logic            ram_ce,
  output logic            ram_we,
  output logic [AW-1:0]   ram_addr,
  output logic [DW/8-1:0] ram_sel,
  output logic [DW-1:0]   ram_wdata,
  input  logic [DW-1:0]   ram_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]     perf_m0_stall,
  output logic [31:0]     perf_conflict
`endif
);

  localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, ACK0, ACK1} state_t;

  state_t     r_state;
  state_t     w_nextState;
  logic [3:0] r_waitCnt;
  logic       r_locked;
  logic       r_wasWrite;
  logic       w_grant0;
  logic       w_grant1;

  // Pick a winner in IDLE: burst owner first, then a starved m1, then m0, then m1
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (r_state == IDLE) begin
      if (m1_req && (r_locked || (r_waitCnt == LP_MAX_WAIT))) begin
        w_grant1 = 1'b1;
      end else if (m0_req) begin
        w_grant0 = 1'b1;
      end else if (m1_req) begin
        w_grant1 = 1'b1;
      end
    end
  end

  // Next state plus every output; anything the current state does not own is 0,
  // and the whole output set collapses to 0 the moment reset is asserted
  always_comb begin
    w_nextState = r_state;
    ram_ce      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_sel     = '0;
    ram_wdata   = '0;
    m0_ack      = 1'b0;
    m0_rdata    = '0;
    m1_ack      = 1'b0;
    m1_rdata    = '0;
    m0_stallreq = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant0) begin
          ram_ce      = 1'b1;
          ram_we      = m0_we;
          ram_addr    = m0_addr;
          ram_sel     = m0_sel;
          ram_wdata   = m0_wdata;
          w_nextState = ACK0;
        end else if (w_grant1) begin
          ram_ce      = 1'b1;
          ram_we      = m1_we;
          ram_addr    = m1_addr;
          ram_sel     = m1_sel;
          ram_wdata   = m1_wdata;
          w_nextState = ACK1;
        end
      end
      ACK0: begin
        m0_ack      = 1'b1;
        m0_rdata    = r_wasWrite ? '0 : ram_rdata;
        w_nextState = IDLE;
      end
      ACK1: begin
        m1_ack      = 1'b1;
        m1_rdata    = r_wasWrite ? '0 : ram_rdata;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
    m0_stallreq = m0_req & ~m0_ack;
    if (!rst) begin
      ram_ce      = 1'b0;
      ram_we      = 1'b0;
      ram_addr    = '0;
      ram_sel     = '0;
      ram_wdata   = '0;
      m0_ack      = 1'b0;
      m0_rdata    = '0;
      m1_ack      = 1'b0;
      m1_rdata    = '0;
      m0_stallreq = 1'b0;
    end
  end

  // State register, plus whether the issued beat was a write (its ack returns 0 data)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_wasWrite <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_grant0) begin
        r_wasWrite <= m0_we;
      end else if (w_grant1) begin
        r_wasWrite <= m1_we;
      end
    end
  end

  // Count m0 grants that jumped ahead of a waiting m1; saturates at MAX_WAIT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_waitCnt <= '0;
    end else if (!m1_req || w_grant1) begin
      r_waitCnt <= '0;
    end else if (w_grant0 && (r_waitCnt < LP_MAX_WAIT)) begin
      r_waitCnt <= r_waitCnt + 4'd1;
    end
  end

  // Burst lock: sampled from m1_lock at each m1 ack, dropped once m1 goes quiet
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_locked <= 1'b0;
    end else if (r_state == ACK1) begin
      r_locked <= m1_lock;
    end else if ((r_state == IDLE) && !m1_req) begin
      r_locked <= 1'b0;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] r_perfStall;
  logic [31:0] r_perfConflict;

  // Free-running wrap-around counters of CPU stall cycles and IDLE contention
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perfStall    <= '0;
      r_perfConflict <= '0;
    end else begin
      if (m0_stallreq) begin
        r_perfStall <= r_perfStall + 32'd1;
      end
      if ((r_state == IDLE) && m0_req && m1_req) begin
        r_perfConflict <= r_perfConflict + 32'd1;
      end
    end
  end

  assign perf_m0_stall = r_perfStall;
  assign perf_conflict = r_perfConflict;
`endif

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Testbench for data_ram_arbiter: a small RAM model on the ram_* side, a
// transaction-level reference model checked every negedge, and directed
// scenarios with literal expectations.
module tb_data_ram_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_we, m0_ack, m0_stallreq;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_sel;
  logic        m1_req, m1_we, m1_lock, m1_ack;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_sel;
  logic        ram_ce, ram_we;
  logic [31:0] ram_addr, ram_wdata;
  logic [3:0]  ram_sel;
  logic [31:0] ram_rdata = 32'h0;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_m0_stall, perf_conflict;
`endif

  int checks = 0;
  int errors = 0;

  data_ram_arbiter #(.AW(32), .DW(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_sel(m0_sel),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m0_stallreq(m0_stallreq),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_sel(m1_sel),
    .m1_wdata(m1_wdata), .m1_lock(m1_lock), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef ARB_PERF_CNT_EN
    , .perf_m0_stall(perf_m0_stall), .perf_conflict(perf_conflict)
`endif
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM the arbiter drives: write commits at the issue edge, read data registered
  logic [31:0] mem [16];
  always @(posedge clk) begin
    logic [31:0] word;
    if (ram_ce) begin
      word = mem[ram_addr[5:2]];
      for (int b = 0; b < 4; b++) begin
        if (ram_sel[b]) word[8*b +: 8] = ram_wdata[8*b +: 8];
      end
      if (ram_we) mem[ram_addr[5:2]] <= word;
      ram_rdata <= mem[ram_addr[5:2]];
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int m, input logic req, input logic we,
                               input logic [31:0] addr, input logic [3:0] sel,
                               input logic [31:0] wdata, input logic lock);
    if (m == 0) begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_sel = sel; m0_wdata = wdata;
    end else begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_sel = sel; m1_wdata = wdata;
      m1_lock = lock;
    end
  endtask

  // Reference model: who owes an ack next cycle, how long m1 has been passed over,
  // whether m1 holds a burst, and an independent copy of memory contents
  int          mOwed = 0;
  logic        mAckWrite = 1'b0;
  logic [31:0] mAckData = 32'h0;
  int          mPassedOver = 0;
  bit          mBurst = 1'b0;
  logic [31:0] shadow [16];
  int          mPerfStall = 0;
  int          mPerfConf = 0;
  int          ackLog[$];

  logic        eCe, eWe, eAck0, eAck1, eStall;
  logic [31:0] eAddr, eWdata, eRd0, eRd1;
  logic [3:0]  eSel;
  int          win;
  bit          wasIdle;

  // Every negedge: derive expected outputs from the model, compare, then advance it
  always @(negedge clk) begin
    eCe = 0; eWe = 0; eAddr = 0; eSel = 0; eWdata = 0;
    eAck0 = 0; eAck1 = 0; eRd0 = 0; eRd1 = 0; eStall = 0; win = 0;
    wasIdle = (mOwed == 0);
    if (!rst) begin
      mOwed = 0; mPassedOver = 0; mBurst = 0; mPerfStall = 0; mPerfConf = 0;
    end else begin
      if (mOwed == 1) begin
        eAck0 = 1; eRd0 = mAckWrite ? 32'h0 : mAckData;
      end else if (mOwed == 2) begin
        eAck1 = 1; eRd1 = mAckWrite ? 32'h0 : mAckData;
      end else begin
        if (m1_req && (mBurst || mPassedOver >= MAX_WAIT)) win = 2;
        else if (m0_req) win = 1;
        else if (m1_req) win = 2;
        if (win == 1) begin
          eCe = 1; eWe = m0_we; eAddr = m0_addr; eSel = m0_sel; eWdata = m0_wdata;
        end else if (win == 2) begin
          eCe = 1; eWe = m1_we; eAddr = m1_addr; eSel = m1_sel; eWdata = m1_wdata;
        end
      end
      eStall = m0_req && !eAck0;
    end
    checkOutput("ram_ce", 64'(ram_ce), 64'(eCe));
    checkOutput("ram_we", 64'(ram_we), 64'(eWe));
    checkOutput("ram_addr", 64'(ram_addr), 64'(eAddr));
    checkOutput("ram_sel", 64'(ram_sel), 64'(eSel));
    checkOutput("ram_wdata", 64'(ram_wdata), 64'(eWdata));
    checkOutput("m0_ack", 64'(m0_ack), 64'(eAck0));
    checkOutput("m0_rdata", 64'(m0_rdata), 64'(eRd0));
    checkOutput("m1_ack", 64'(m1_ack), 64'(eAck1));
    checkOutput("m1_rdata", 64'(m1_rdata), 64'(eRd1));
    checkOutput("m0_stallreq", 64'(m0_stallreq), 64'(eStall));
`ifdef ARB_PERF_CNT_EN
    checkOutput("perf_m0_stall", 64'(perf_m0_stall), 64'(32'(mPerfStall)));
    checkOutput("perf_conflict", 64'(perf_conflict), 64'(32'(mPerfConf)));
`endif
    if (rst) begin
      if (m0_ack) ackLog.push_back(0);
      if (m1_ack) ackLog.push_back(1);
      if (eStall) mPerfStall++;
      if (wasIdle && m0_req && m1_req) mPerfConf++;
      if (!wasIdle) begin
        if (mOwed == 2) mBurst = m1_lock;
        mOwed = 0;
      end else begin
        if (!m1_req) mBurst = 0;
        if (win != 0) begin
          mOwed = win;
          mAckWrite = eWe;
          mAckData = shadow[eAddr[5:2]];
          if (eWe) begin
            for (int b = 0; b < 4; b++) begin
              if (eSel[b]) shadow[eAddr[5:2]][8*b +: 8] = eWdata[8*b +: 8];
            end
          end
        end
      end
      if (!m1_req || win == 2) mPassedOver = 0;
      else if (win == 1 && mPassedOver < MAX_WAIT) mPassedOver++;
    end
  end

  // Directed scenarios with hand-computed literal expectations
  initial begin
    int startIdx;
    logic stallAll;
    rst = 1'b0;
    applyStimulus(0, 0, 0, 32'h0, 4'h0, 32'h0, 0);
    applyStimulus(1, 0, 0, 32'h0, 4'h0, 32'h0, 0);
    for (int i = 0; i < 16; i++) begin
      mem[i] = 32'h1000_0000 + i;
      shadow[i] = 32'h1000_0000 + i;
    end
    mem[2] = 32'h1122_3344;
    shadow[2] = 32'h1122_3344;

    // Reset holds everything at 0 even with a request pending
    repeat (2) @(posedge clk);
    #1 m0_req = 1'b1;
    #1 checkOutput("reset stallreq gated", 64'(m0_stallreq), 64'h0);
    checkOutput("reset ram_ce gated", 64'(ram_ce), 64'h0);
    m0_req = 1'b0;
    rst = 1'b1;

    // Scenario: single m0 read of word 0x8
    @(posedge clk); #1 applyStimulus(0, 1, 0, 32'h8, 4'hF, 32'h0, 0);
    @(negedge clk);
    checkOutput("rd issue ram_ce", 64'(ram_ce), 64'h1);
    checkOutput("rd issue ram_addr", 64'(ram_addr), 64'h8);
    checkOutput("rd issue stallreq", 64'(m0_stallreq), 64'h1);
    @(negedge clk);
    checkOutput("rd ack", 64'(m0_ack), 64'h1);
    checkOutput("rd data", 64'(m0_rdata), 64'h1122_3344);
    checkOutput("rd ack stallreq", 64'(m0_stallreq), 64'h0);
    @(posedge clk); #1 applyStimulus(0, 0, 0, 32'h0, 4'h0, 32'h0, 0);

    // Scenario: halfword write to 0x4 then readback
    @(posedge clk); #1 applyStimulus(0, 1, 1, 32'h4, 4'b0011, 32'hAABB_CCDD, 0);
    @(negedge clk);
    checkOutput("wr ram_we", 64'(ram_we), 64'h1);
    checkOutput("wr ram_sel", 64'(ram_sel), 64'h3);
    checkOutput("wr ram_wdata", 64'(ram_wdata), 64'hAABB_CCDD);
    @(negedge clk);
    checkOutput("wr ack", 64'(m0_ack), 64'h1);
    checkOutput("wr ack rdata", 64'(m0_rdata), 64'h0);
    @(posedge clk); #1 applyStimulus(0, 1, 0, 32'h4, 4'hF, 32'h0, 0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("readback ack", 64'(m0_ack), 64'h1);
    checkOutput("readback low half", 64'(m0_rdata[15:0]), 64'hCCDD);
    checkOutput("readback word", 64'(m0_rdata), 64'h1000_CCDD);
    @(posedge clk); #1 applyStimulus(0, 0, 0, 32'h0, 4'h0, 32'h0, 0);

    // Short reset pulse so performance counters start from zero
    @(posedge clk); #1 rst = 1'b0;
`ifdef ARB_PERF_CNT_EN
    #1 checkOutput("perf stall after reset", 64'(perf_m0_stall), 64'h0);
    checkOutput("perf conflict after reset", 64'(perf_conflict), 64'h0);
`endif
    #1 rst = 1'b1;

    // Scenario: both masters requesting for 20 cycles
    startIdx = ackLog.size();
    @(posedge clk); #1;
    applyStimulus(0, 1, 0, 32'h8, 4'hF, 32'h0, 0);
    applyStimulus(1, 1, 0, 32'hC, 4'hF, 32'h0, 0);
    repeat (20) @(posedge clk);
    #1;
`ifdef ARB_PERF_CNT_EN
    checkOutput("perf conflict 20 cycles", 64'(perf_conflict), 64'd10);
    checkOutput("perf stall 20 cycles", 64'(perf_m0_stall), 64'd12);
`endif
    applyStimulus(0, 0, 0, 32'h0, 4'h0, 32'h0, 0);
    applyStimulus(1, 0, 0, 32'h0, 4'h0, 32'h0, 0);
    repeat (2) @(posedge clk);
    checkOutput("fair ack count", 64'(ackLog.size() - startIdx), 64'd10);
    for (int i = 0; i < 10 && startIdx + i < ackLog.size(); i++) begin
      checkOutput($sformatf("fair grant %0d", i), 64'(ackLog[startIdx + i]), 64'((i % 5) == 4));
    end

    // Scenario: locked m1 burst of three while m0 waits
    startIdx = ackLog.size();
    stallAll = 1'b1;
    @(posedge clk); #1 applyStimulus(1, 1, 0, 32'h10, 4'hF, 32'h0, 1);
    @(posedge clk); #1 applyStimulus(0, 1, 0, 32'h8, 4'hF, 32'h0, 0);
    @(negedge clk); stallAll &= m0_stallreq;
    @(posedge clk); #1 applyStimulus(1, 1, 0, 32'h14, 4'hF, 32'h0, 1);
    @(negedge clk); stallAll &= m0_stallreq;
    @(negedge clk); stallAll &= m0_stallreq;
    @(posedge clk); #1 applyStimulus(1, 1, 0, 32'h18, 4'hF, 32'h0, 0);
    @(negedge clk); stallAll &= m0_stallreq;
    @(negedge clk); stallAll &= m0_stallreq;
    @(posedge clk); #1 applyStimulus(1, 0, 0, 32'h0, 4'h0, 32'h0, 0);
    @(negedge clk); stallAll &= m0_stallreq;
    checkOutput("burst stall held", 64'(stallAll), 64'h1);
    @(negedge clk);
    checkOutput("post-burst m0 ack", 64'(m0_ack), 64'h1);
    checkOutput("post-burst m0 data", 64'(m0_rdata), 64'h1122_3344);
    @(posedge clk); #1 applyStimulus(0, 0, 0, 32'h0, 4'h0, 32'h0, 0);
    checkOutput("burst ack count", 64'(ackLog.size() - startIdx), 64'd4);
    for (int i = 0; i < 4 && startIdx + i < ackLog.size(); i++) begin
      checkOutput($sformatf("burst order %0d", i), 64'(ackLog[startIdx + i]), 64'(i < 3));
    end

    // Scenario: reset lands in the ack cycle of an m0 read
    startIdx = ackLog.size();
    @(posedge clk); #1 applyStimulus(0, 1, 0, 32'h8, 4'hF, 32'h0, 0);
    @(posedge clk); #1 rst = 1'b0;
    #1;
    checkOutput("reset drops m0_ack", 64'(m0_ack), 64'h0);
    checkOutput("reset m0_rdata", 64'(m0_rdata), 64'h0);
    checkOutput("reset stallreq", 64'(m0_stallreq), 64'h0);
    checkOutput("reset ram_ce", 64'(ram_ce), 64'h0);
    applyStimulus(0, 0, 0, 32'h0, 4'h0, 32'h0, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 applyStimulus(1, 1, 0, 32'hC, 4'hF, 32'h0, 0);
    @(negedge clk);
    checkOutput("post-reset m1 issue", 64'(ram_ce), 64'h1);
    checkOutput("post-reset m1 addr", 64'(ram_addr), 64'hC);
    @(negedge clk);
    checkOutput("post-reset m1 ack", 64'(m1_ack), 64'h1);
    checkOutput("post-reset m1 data", 64'(m1_rdata), 64'h1000_0003);
    @(posedge clk); #1 applyStimulus(1, 0, 0, 32'h0, 4'h0, 32'h0, 0);
    checkOutput("reset ack log", 64'(ackLog.size() - startIdx), 64'd1);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_ram_arbiter.md
Name: data_ram_arbiter

Overview:
- Two-master, single-slave arbiter that shares the data RAM between the CPU data-memory port (m0) and a DMA/debug loader port (m1).
- Sits between openmips and data_ram inside openmips_min_sopc.
- Drives the RAM with single-beat transactions.
- Returns rdata and ack to the winning master and raises a stall request toward the CPU pipeline while m0 waits.

Parameters:
- AW, 32, address width for both masters and the RAM port
- DW, 32, data width; byte-select width is DW/8
- MAX_WAIT, 4, consecutive m0 grants tolerated while m1 is pending before m1 is forced (1..15)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- m0_req  in  1  CPU request; held with its address and data until m0_ack
- m0_we  in  1  1 = write
- m0_addr  in  AW  byte address
- m0_sel  in  DW/8  byte enables
- m0_wdata  in  DW  write data
- m0_rdata  out  DW  read data, valid with m0_ack
- m0_ack  out  1  one-cycle completion pulse
- m0_stallreq  out  1  m0_req & ~m0_ack, to the pipeline control
- m1_req, m1_we, m1_addr, m1_sel, m1_wdata  in  as m0  DMA/debug request
- m1_lock  in  1  keep the grant for the next m1 beat (burst)
- m1_rdata  out  DW  read data
- m1_ack  out  1  completion pulse
- ram_ce  out  1  RAM chip enable
- ram_we  out  1  RAM write enable
- ram_addr  out  AW  RAM address
- ram_sel  out  DW/8  RAM byte enables
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data, registered by the RAM, valid the cycle after ram_ce

Behaviour:
- FSM states: IDLE, ACK0, ACK1. Each transaction takes 2 cycles: issue, then ack. Max throughput is 1 beat per 2 cycles.
- IDLE, issue cycle:
  - The winner's signals are muxed combinationally onto ram_* with ram_ce=1.
  - Next state is ACK0 or ACK1. With no request, ram_ce=0 and the FSM stays in IDLE.
- ACKx: mx_ack=1 and mx_rdata=ram_rdata (write: rdata=0). ram_ce=0. Next state is IDLE.
- Winner selection in IDLE, in order:
  - locked==1 and m1_req: m1 wins.
  - wait_cnt==MAX_WAIT and m1_req: m1 wins.
  - m0_req: m0 wins.
  - m1_req: m1 wins.
- wait_cnt (4 bits):
  - Increments when m0 is granted while m1_req=1.
  - Clears when m1 is granted or when m1_req=0.
  - Saturates at MAX_WAIT.
- locked:
  - Set in ACK1 if m1_lock=1.
  - Cleared in ACK1 if m1_lock=0, or in IDLE if m1_req=0.
  - While locked, m0 stalls indefinitely. Software bounds bursts.
- Outputs not owned by the current state are 0: acks, rdata, all ram_* when ram_ce=0.
- m0_stallreq is combinational and is 0 in the ACK0 cycle.
- A master that drops req before its ack gets no ack in IDLE. Once issued, the ack is always delivered.
- A write is committed by the RAM in the issue cycle.
- Reset (rst=0, any time):
  - State goes to IDLE, wait_cnt=0, locked=0.
  - All outputs are 0 immediately.
  - An in-flight ack is dropped; a write issued that cycle may or may not complete.
- Both req asserted, wait_cnt<MAX_WAIT, not locked: m0 wins.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- When defined, adds outputs perf_m0_stall[31:0] and perf_conflict[31:0]:
  - perf_m0_stall counts cycles with m0_stallreq=1.
  - perf_conflict counts IDLE cycles with both req=1.
  - Both counters wrap at 2^32 and reset to 0.
- When undefined, those ports and counters are absent. All other behaviour is identical.

Test Plan:
- m0 read only, addr=0x0000_0008, RAM word 0x1122_3344 -> ram_ce at cycle 1, m0_ack and m0_rdata=0x1122_3344 at cycle 2, stallreq 1 then 0.
- m0 write sel=4'b0011 wdata=0xAABB_CCDD addr=0x4 -> ram_we=1, ram_sel=0011 in issue cycle; m0_ack next; readback gives low halfword 0xCCDD.
- m0 and m1 requesting continuously, MAX_WAIT=4 -> grant order m0,m0,m0,m0,m1 repeating; wait_cnt never exceeds 4.
- m1 burst of 3 with m1_lock=1,1,0 while m0 requests -> three m1 acks before any m0 ack; m0_stallreq held high throughout.
- Reset asserted during ACK0 of an m0 read -> no m0_ack; all outputs 0 asynchronously; after release the first m1 request completes in 2 cycles.
- ARB_PERF_CNT_EN defined, scenario 3 run for 20 cycles -> perf_conflict and perf_m0_stall match bench-model counts; both read 0 after reset.
